// File: rtl/rgb_pkg.sv
// rgb_pkg: constants shared by the RGB PWM fader.
// PWM width default, channel indices into color_rgb, FSM states.
package rgb_pkg;

  localparam int PWM_BITS_DEF = 8;

  localparam int N_CH = 3;
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

endpackage

// File: rtl/rgb_channel_ramp.sv
// rgb_channel_ramp: one colour channel, duty ramps toward target.
// Ports: i_load latches i_target, i_step moves duty by at most STEP,
// i_pwm_cnt is the shared frame counter, o_pwm is the registered PWM,
// o_done_next says duty will equal target once the pending step lands.
module rgb_channel_ramp
  import rgb_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int STEP     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [PWM_BITS-1:0] i_target,
  input  logic                i_step,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_pwm,
  output logic                o_done_next
);

  localparam logic [PWM_BITS:0] W_STEP = (PWM_BITS+1)'(STEP);

  logic [PWM_BITS-1:0] r_duty;
  logic [PWM_BITS-1:0] r_target;
  logic                r_pwm;

  logic [PWM_BITS:0] w_duty_x;
  logic [PWM_BITS:0] w_tgt_x;
  logic [PWM_BITS:0] w_diff;
  logic [PWM_BITS:0] w_delta;
  logic [PWM_BITS:0] w_next_x;

  // Extra bit keeps the distance and the clamp free of wrap-around.
  always_comb begin
    w_duty_x = {1'b0, r_duty};
    w_tgt_x  = {1'b0, r_target};
    w_diff   = '0;
    w_delta  = '0;
    w_next_x = w_duty_x;
    if (w_tgt_x > w_duty_x) begin
      w_diff   = w_tgt_x - w_duty_x;
      w_delta  = (w_diff < W_STEP) ? w_diff : W_STEP;
      w_next_x = w_duty_x + w_delta;
    end else if (w_duty_x > w_tgt_x) begin
      w_diff   = w_duty_x - w_tgt_x;
      w_delta  = (w_diff < W_STEP) ? w_diff : W_STEP;
      w_next_x = w_duty_x - w_delta;
    end
  end

  assign o_done_next = (w_next_x == w_tgt_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty   <= '0;
      r_target <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_load) r_target <= i_target;
      if (i_step) r_duty <= w_next_x[PWM_BITS-1:0];
      r_pwm <= (i_pwm_cnt < r_duty);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: colour targets in, three glitch-free fading PWMs out.
// Ports: color_valid/color_ready/color_rgb handshake ({R,G,B}),
// red/green/blue_pwm to the LED driver, busy while ramping,
// frame_tick one clock after each PWM frame wrap.
module rgb_pwm_fader
  import rgb_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int PRESCALE    = 47,
  parameter int RAMP_FRAMES = 4,
  parameter int STEP        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  color_valid,
  output logic                  color_ready,
  input  logic [3*PWM_BITS-1:0] color_rgb,
  output logic                  red_pwm,
  output logic                  green_pwm,
  output logic                  blue_pwm,
  output logic                  busy,
  output logic                  frame_tick
);

  localparam int PS_W =
    (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int FR_W =
    (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;

  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE);
  localparam logic [FR_W-1:0] FR_MAX = FR_W'(RAMP_FRAMES - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  state_t r_state;
  state_t w_state_nx;

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [FR_W-1:0]     r_frm_cnt;
  logic                r_frame_tick;

  logic            w_tick;
  logic            w_frame_end;
  logic            w_accept;
  logic            w_step;
  logic            w_all_done;
  logic [N_CH-1:0] w_pwm;
  logic [N_CH-1:0] w_done;

  assign w_tick      = (r_presc == PS_MAX);
  assign w_frame_end = w_tick && (r_pwm_cnt == CNT_MAX);
  assign color_ready = (r_state == ST_IDLE);
  assign busy        = (r_state == ST_RAMP);
  assign w_accept    = color_valid && color_ready;
  assign w_step      = busy && w_frame_end &&
                       (r_frm_cnt == FR_MAX);
  assign w_all_done  = &w_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_pwm_cnt    <= '0;
      r_frm_cnt    <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_frame_tick <= w_frame_end;
      // An accept on a frame edge restarts the count; that
      // edge does not count toward the first step.
      if (w_accept) begin
        r_frm_cnt <= '0;
      end else if (busy && w_frame_end) begin
        r_frm_cnt <= (r_frm_cnt == FR_MAX) ?
                     '0 : r_frm_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept) w_state_nx = ST_RAMP;
      ST_RAMP: if (w_step && w_all_done) w_state_nx = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    rgb_channel_ramp #(
      .PWM_BITS(PWM_BITS),
      .STEP    (STEP)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_accept),
      .i_target   (color_rgb[i*PWM_BITS +: PWM_BITS]),
      .i_step     (w_step),
      .i_pwm_cnt  (r_pwm_cnt),
      .o_pwm      (w_pwm[i]),
      .o_done_next(w_done[i])
    );
  end

  assign red_pwm    = w_pwm[CH_R];
  assign green_pwm  = w_pwm[CH_G];
  assign blue_pwm   = w_pwm[CH_B];
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: per-frame PWM widths checked against a ramp model.
// Directed table, backpressure, reset mid-ramp, random targets.
module tb_rgb_pwm_fader;

  localparam int PS   = 1;
  localparam int RF   = 2;
  localparam int ST   = 63;
  localparam int FCLK = 256 * (PS + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        color_valid;
  logic        color_ready;
  logic [23:0] color_rgb;
  logic        red_pwm;
  logic        green_pwm;
  logic        blue_pwm;
  logic        busy;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  int md[3];
  int cnt[3];

  typedef struct {
    logic [23:0] rgb;
    bit          aligned;
    int          steps;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  rgb_pwm_fader #(
    .PWM_BITS   (8),
    .PRESCALE   (PS),
    .RAMP_FRAMES(RF),
    .STEP       (ST)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .color_valid(color_valid),
    .color_ready(color_ready),
    .color_rgb  (color_rgb),
    .red_pwm    (red_pwm),
    .green_pwm  (green_pwm),
    .blue_pwm   (blue_pwm),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string name, input int act,
                     input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  function automatic int toward(input int d, input int t);
    if (t > d) return (t - d < ST) ? t : d + ST;
    if (d > t) return (d - t < ST) ? t : d - ST;
    return d;
  endfunction

  task automatic chk_duty(input string name);
    for (int k = 0; k < 3; k++)
      chk($sformatf("%s_ch%0d", name, k), cnt[k],
          md[k] * (PS + 1));
  endtask

  // Starts on a frame_tick sample, ends on the next one.
  task automatic frame();
    int n = 0;
    cnt = '{0, 0, 0};
    do begin
      cnt[0] += int'(red_pwm);
      cnt[1] += int'(green_pwm);
      cnt[2] += int'(blue_pwm);
      @(negedge clk);
      color_valid = 1'b0;
      n++;
    end while (!frame_tick && n < 2 * FCLK);
    chk("frame_len", n, FCLK);
  endtask

  task automatic sync();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 2 * FCLK);
    if (!frame_tick) chk("sync_timeout", n, FCLK);
  endtask

  task automatic ramp(input logic [23:0] rgb,
                      input bit aligned, output int steps);
    int  t[3];
    int  j;
    bit  done;
    t[0] = int'(rgb[23:16]);
    t[1] = int'(rgb[15:8]);
    t[2] = int'(rgb[7:0]);
    steps = 0;
    sync();
    chk("ready_idle", int'(color_ready), 1);
    color_rgb = rgb;
    if (aligned) begin
      repeat (FCLK - 1) @(negedge clk);
      color_valid = 1'b1;
      @(negedge clk);
      color_valid = 1'b0;
      chk("align_tick", int'(frame_tick), 1);
      chk("align_busy", int'(busy), 1);
    end else begin
      color_valid = 1'b1;
    end
    j = 0;
    done = 1'b0;
    while (!done && j < 64) begin
      frame();
      chk_duty("duty");
      j++;
      if (j % RF == 0) begin
        done = 1'b1;
        for (int k = 0; k < 3; k++) begin
          md[k] = toward(md[k], t[k]);
          if (md[k] != t[k]) done = 1'b0;
        end
        steps++;
      end
      chk("busy", int'(busy), done ? 0 : 1);
      chk("ready", int'(color_ready), done ? 1 : 0);
    end
    frame();
    chk_duty("duty_final");
  endtask

  initial begin
    int n;
    int steps;
    vecs[0] = '{24'hFF0000, 1'b0, 5};
    vecs[1] = '{24'h804006, 1'b1, 3};
    vecs[2] = '{24'h804006, 1'b0, 1};
    vecs[3] = '{24'h000000, 1'b0, 3};
    md = '{0, 0, 0};

    rst = 1'b1;
    color_valid = 1'b0;
    color_rgb = '0;
    repeat (2) @(negedge clk);
    chk("rst_red", int'(red_pwm), 0);
    chk("rst_green", int'(green_pwm), 0);
    chk("rst_blue", int'(blue_pwm), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(color_ready), 1);
    chk("rst_tick", int'(frame_tick), 0);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 2 * FCLK);
    chk("first_tick", n, FCLK);
    frame();
    chk_duty("idle_zero");

    for (int i = 0; i < 4; i++) begin
      ramp(vecs[i].rgb, vecs[i].aligned, steps);
      chk($sformatf("steps_v%0d", i), steps, vecs[i].steps);
    end

    // Backpressure: 0x123456 held while ramping to 0x404040.
    sync();
    color_rgb = 24'h404040;
    color_valid = 1'b1;
    @(negedge clk);
    chk("bp_busy", int'(busy), 1);
    chk("bp_notready", int'(color_ready), 0);
    color_rgb = 24'h123456;
    n = 0;
    while (!color_ready && n < 8 * FCLK) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait", n, 4 * FCLK - 1);
    @(negedge clk);
    color_valid = 1'b0;
    chk("bp_accept", int'(busy), 1);
    n = 0;
    while (!color_ready && n < 8 * FCLK) begin
      @(negedge clk);
      n++;
    end
    chk("bp_wait2", n, 2 * FCLK - 1);
    md = '{8'h12, 8'h34, 8'h56};
    sync();
    frame();
    chk_duty("bp_duty");
    chk("bp_once", int'(color_ready), 1);

    // Reset in the middle of a ramp.
    sync();
    color_rgb = 24'hC8C8C8;
    color_valid = 1'b1;
    repeat (3 * FCLK) begin
      @(negedge clk);
      color_valid = 1'b0;
    end
    chk("mid_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_red", int'(red_pwm), 0);
    chk("mrst_green", int'(green_pwm), 0);
    chk("mrst_blue", int'(blue_pwm), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_ready", int'(color_ready), 1);
    md = '{0, 0, 0};
    sync();
    frame();
    chk_duty("mrst_duty");

    for (int i = 0; i < 4; i++) begin
      ramp(24'($urandom), 1'($urandom_range(0, 1)), steps);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
